// File: rtl/wc_tile_sequencer.sv
// rtl/wc_tile_sequencer.sv - tile issue sequencer for the fixed-latency Winograd core
// Credits cover FIFO entries plus tiles still inside the core, so a core result always has a slot.
module wc_tile_sequencer #(
    parameter int DW     = 10,
    parameter int NIN    = 9,
    parameter int NOUT   = 5,
    parameter int LAT    = 3,
    parameter int FDEPTH = 4,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNTW-1:0]      num_tiles,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW*NIN-1:0]    in_data,
    output logic [DW*NIN-1:0]    core_d,
    input  logic [DW*NOUT-1:0]   core_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW*NOUT-1:0]   out_data,
    output logic                 out_last
);
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH) + 1;
    localparam int ZW = DW * NOUT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [CNTW-1:0] total;
    logic [CNTW-1:0] issued;
    logic [CNTW-1:0] retired;
    logic [LAT:0]    vpipe;
    logic [ZW:0]     fifo_mem [FDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   credits;
    logic            issue;
    logic            push;
    logic            pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + CW'(vpipe[i]);
        end
    end

    // inflight + fifo_count never exceeds FDEPTH, so this cannot go negative
    assign credits   = CW'(FDEPTH) - fifo_count - inflight;
    assign in_ready  = (state == RUN) && (issued < total) && (credits != '0);
    assign issue     = in_valid && in_ready;
    assign push      = vpipe[LAT];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_mem[rd_ptr][ZW-1:0];
    assign out_last  = out_valid && fifo_mem[rd_ptr][ZW];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {(retired + CNTW'(1)) == total, core_z};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            total      <= '0;
            issued     <= '0;
            retired    <= '0;
            vpipe      <= '0;
            core_d     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done  <= 1'b0;
            vpipe <= {vpipe[LAT-1:0], issue};
            if (issue) begin
                core_d <= in_data;
                issued <= issued + CNTW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                retired <= retired + CNTW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case (state)
                IDLE: begin
                    if (start) begin
                        total   <= num_tiles;
                        issued  <= '0;
                        retired <= '0;
                        if (num_tiles == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (issued + CNTW'(1)) == total) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_count == CW'(FDEPTH)));
        end
    end
endmodule
